uart_rx_ctrl: RTL and testbench

Receive-side sequencer for the UART receiver. It owns the oversampling edge counter and bit counter, and walks the frame start → data → optional parity → stop. It drives enables to the data sampler, deserializer and parity-bit checker, and collects their results into frame-level valid/error outputs. It sits between the rx line synchronizer and the receiver's parallel data register.

---
 rtl/uart_rx_ctrl.sv | 141 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer: start/data/parity/stop walk, sampler strobes, frame status
// Optional break detector output enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  sampled_bit,
    input  logic                  par_bit_error,
    output logic                  sample_en,
    output logic                  deser_en,
    output logic                  par_chk_en,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stop_err,
`ifdef UART_RX_BREAK_DET_EN
    output logic                  break_det,
`endif
    output logic                  busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam int BW = $clog2(DATA_WIDTH + 1);

    logic [2:0]            r_state;
    logic [PRESCALE_W-1:0] r_edge_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [PRESCALE_W-1:0] r_prescale;
    logic                  r_par_en;
    logic                  r_par_err;
    logic                  r_stop_err;
    logic                  r_busy;

    logic [2:0]            w_state_nxt;
    logic [PRESCALE_W-1:0] w_p_eff;
    logic [PRESCALE_W-1:0] w_mid;
    logic                  w_edge_last;
    logic                  w_at_check;
    logic                  w_at_cap;
    logic                  w_active;

    assign w_p_eff     = (prescale == PRESCALE_W'(16) || prescale == PRESCALE_W'(32))
                         ? prescale : PRESCALE_W'(8);
    assign w_mid       = r_prescale >> 1;
    assign w_edge_last = (r_edge_cnt == r_prescale - PRESCALE_W'(1));
    assign w_at_check  = (r_edge_cnt == w_mid + PRESCALE_W'(2));
    assign w_at_cap    = (r_edge_cnt == w_mid + PRESCALE_W'(3));
    assign w_active    = (r_state != S_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (!rx_in) w_state_nxt = S_START;
            S_START: begin
                if (w_at_check && sampled_bit) w_state_nxt = S_IDLE;
                else if (w_edge_last)          w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_edge_last && r_bit_cnt == BW'(DATA_WIDTH - 1))
                    w_state_nxt = r_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: if (w_edge_last) w_state_nxt = S_STOP;
            S_STOP:   if (w_edge_last) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_prescale <= '0;
            r_par_en   <= 1'b0;
            r_par_err  <= 1'b0;
            r_stop_err <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            if (!w_active) begin
                r_edge_cnt <= '0;
                r_bit_cnt  <= '0;
                if (!rx_in) begin
                    r_prescale <= w_p_eff;
                    r_par_en   <= par_en;
                    r_par_err  <= 1'b0;
                    r_stop_err <= 1'b0;
                end
            end else begin
                // A glitch abort also lands here, so the counter restarts for the next start bit
                if (w_edge_last || w_state_nxt == S_IDLE)
                    r_edge_cnt <= '0;
                else
                    r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
                if (r_state == S_DATA && w_edge_last)
                    r_bit_cnt <= r_bit_cnt + BW'(1);
                if (r_state == S_PARITY && w_at_cap)
                    r_par_err <= par_bit_error;
                if (r_state == S_STOP && w_at_check)
                    r_stop_err <= ~sampled_bit;
            end
        end
    end

    assign sample_en  = w_active && (r_edge_cnt == w_mid - PRESCALE_W'(1) ||
                                     r_edge_cnt == w_mid ||
                                     r_edge_cnt == w_mid + PRESCALE_W'(1));
    assign deser_en   = (r_state == S_DATA)   && w_at_check;
    assign par_chk_en = (r_state == S_PARITY) && w_at_check;
    assign data_valid = (r_state == S_STOP) && w_edge_last && !r_par_err && !r_stop_err;
    assign par_err    = r_par_err;
    assign stop_err   = r_stop_err;
    assign busy       = r_busy;

`ifdef UART_RX_BREAK_DET_EN
    logic r_all_zero;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_all_zero <= 1'b0;
        end else if (!w_active) begin
            r_all_zero <= 1'b1;
        end else if ((r_state == S_DATA || r_state == S_PARITY || r_state == S_STOP)
                     && w_at_check && sampled_bit) begin
            r_all_zero <= 1'b0;
        end
    end

    assign break_det = (r_state == S_STOP) && w_edge_last && r_all_zero;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - table-driven self-checking bench for uart_rx_ctrl
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       sampled_bit;
    logic       par_bit_error = 1'b0;
    logic       sample_en, deser_en, par_chk_en, data_valid, par_err, stop_err, busy;
`ifdef UART_RX_BREAK_DET_EN
    logic       break_det;
`endif

    uart_rx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .rx_in(rx_in), .prescale(prescale),
        .par_en(par_en), .sampled_bit(sampled_bit), .par_bit_error(par_bit_error),
        .sample_en(sample_en), .deser_en(deser_en), .par_chk_en(par_chk_en),
        .data_valid(data_valid), .par_err(par_err), .stop_err(stop_err),
`ifdef UART_RX_BREAK_DET_EN
        .break_det(break_det),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Ideal sampler and an even-parity checker that holds its result for one cycle
    assign sampled_bit = rx_in;
    logic [7:0] cur_data = 8'h00;
    always @(posedge clk) par_bit_error <= par_chk_en ? ((^cur_data) ^ sampled_bit) : 1'b0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_deser = 0, n_valid = 0, n_brk = 0;
    int   t_start = 0, t_valid = 0, t_deser0 = 0, t_par = 0;
    logic prev_busy = 1'b0, prev_par = 1'b0, deser_seen = 1'b0;

    always @(negedge clk) begin
        if (busy && !prev_busy) begin
            t_start    = cyc;
            deser_seen = 1'b0;
        end
        if (deser_en) begin
            n_deser++;
            if (!deser_seen) begin
                t_deser0   = cyc;
                deser_seen = 1'b1;
            end
        end
        if (data_valid) begin
            n_valid++;
            t_valid = cyc;
        end
        if (par_err && !prev_par) t_par = cyc;
`ifdef UART_RX_BREAK_DET_EN
        if (break_det) n_brk++;
`endif
        prev_busy = busy;
        prev_par  = par_err;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int p);
        rx_in = b;
        repeat (p) @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input int ps, input int p, input logic pe,
                               input logic [7:0] d, input logic pb, input logic sb);
        prescale = 6'(ps);
        par_en   = pe;
        cur_data = d;
        drive_bit(1'b0, p);
        prescale = (p == 32) ? 6'd16 : 6'd32;
        par_en   = ~pe;
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        prescale = 6'(ps);
        par_en   = pe;
        if (pe) drive_bit(pb, p);
        drive_bit(sb, p);
        rx_in = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        while (busy && w < 400) begin
            @(posedge clk);
            w++;
        end
        #1;
        check(name, busy, 0);
    endtask

    typedef struct {
        int         ps;
        int         p;
        logic       pe;
        logic [7:0] d;
        logic       pb;
        logic       sb;
        logic       e_pe;
        logic       e_se;
        int         e_v;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int nd, nv, nb, ts;
        tbl[0] = '{16, 16, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[1] = '{ 8,  8, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[2] = '{ 8,  8, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        tbl[3] = '{16, 16, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[4] = '{12,  8, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1};
        tbl[5] = '{32, 32, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[6] = '{ 8,  8, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tbl[7] = '{16, 16, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1};

        reset_n  = 1'b0;
        rx_in    = 1'b1;
        prescale = 6'd16;
        par_en   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", int'({sample_en, deser_en, par_chk_en, data_valid,
                                     par_err, stop_err, busy}), 0);
        reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_after_reset", busy, 0);

        for (int r = 0; r < 8; r++) begin
            nd = n_deser; nv = n_valid; nb = n_brk;
            drive_frame(tbl[r].ps, tbl[r].p, tbl[r].pe, tbl[r].d, tbl[r].pb, tbl[r].sb);
            repeat (6) @(posedge clk);
            #1;
            wait_idle($sformatf("row%0d_idle", r));
            check($sformatf("row%0d_valid_cnt", r), n_valid - nv, tbl[r].e_v);
            check($sformatf("row%0d_par_err", r), par_err, tbl[r].e_pe);
            check($sformatf("row%0d_stop_err", r), stop_err, tbl[r].e_se);
            check($sformatf("row%0d_deser_cnt", r), n_deser - nd, 8);
            check($sformatf("row%0d_deser0_ofs", r), t_deser0 - t_start,
                  tbl[r].p + tbl[r].p / 2 + 2);
            if (tbl[r].e_v == 1)
                check($sformatf("row%0d_valid_ofs", r), t_valid - t_start,
                      (tbl[r].pe ? 11 : 10) * tbl[r].p - 1);
            if (tbl[r].e_pe)
                check($sformatf("row%0d_par_ofs", r), t_par - t_start,
                      9 * tbl[r].p + tbl[r].p / 2 + 4);
`ifdef UART_RX_BREAK_DET_EN
            check($sformatf("row%0d_break", r), n_brk - nb,
                  int'(tbl[r].d == 8'h00 && (!tbl[r].pe || !tbl[r].pb) && !tbl[r].sb));
`endif
        end

        // Start glitch: three low cycles at P=16
        prescale = 6'd16;
        par_en   = 1'b0;
        nd = n_deser; nv = n_valid; ts = t_start;
        rx_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_in = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("glitch_busy_seen", int'(t_start != ts), 1);
        check("glitch_idle", busy, 0);
        check("glitch_deser", n_deser - nd, 0);
        check("glitch_valid", n_valid - nv, 0);

        // Back-to-back frames at P=32
        nd = n_deser; nv = n_valid;
        drive_frame(32, 32, 1'b0, 8'h12, 1'b0, 1'b1);
        drive_frame(32, 32, 1'b0, 8'h34, 1'b0, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        wait_idle("b2b_idle");
        check("b2b_valid_cnt", n_valid - nv, 2);
        check("b2b_deser_cnt", n_deser - nd, 16);

        // Reset during data bit 4 at P=32
        prescale = 6'd32;
        par_en   = 1'b0;
        cur_data = 8'hFF;
        nd = n_deser; nv = n_valid;
        drive_bit(1'b0, 32);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 32);
        rx_in = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("midrst_busy_before", busy, 1);
        check("midrst_deser_before", n_deser - nd, 5);
        reset_n = 1'b0;
        #1;
        check("midrst_outputs", int'({sample_en, deser_en, par_chk_en, data_valid,
                                      par_err, stop_err, busy}), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_idle_after", busy, 0);
        check("midrst_no_valid", n_valid - nv, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
